// File: rtl/blink_gen_pkg.sv
// Shared encodings for the blink generator: channel modes and burst states.
package blink_gen_pkg;

    // Per-channel mode field, channel i uses mode[2i+1:2i].
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // Burst sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;

    // Shortest period the shared counter will run; smaller requests are clamped.
    localparam int unsigned PER_MIN = 2;

endpackage

// File: rtl/blink_gen_ch.sv
// One blink channel: mode mux, burst sequencer and burst-length down-counter.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | no burst; a start strobe in burst mode arms the channel
//  ST_ARMED | waiting for the next period start to begin blinking
//  ST_RUN   | blinking; r_left periods remain, busy asserted
module blink_gen_ch
    import blink_gen_pkg::*;
#(
    parameter int BURST_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [1:0]         i_mode,
    input  logic               i_start,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic               i_cnt_zero,
    input  logic               i_phase_hi,
    output logic               o_blink,
    output logic               o_busy,
    output logic               o_done
);

    logic [1:0]         r_state;
    logic [BURST_W-1:0] r_left;
    logic               r_blink;
    logic               r_busy;
    logic               r_done;

    logic [1:0]         w_state_nxt;
    logic [BURST_W-1:0] w_left_nxt;
    logic               w_done_nxt;
    logic               w_blink_nxt;
    logic               w_burst_mode;

    assign w_burst_mode = (i_mode == MODE_BURST);

    // Burst next-state: leaving burst mode aborts silently, completion pulses done.
    always_comb begin
        w_state_nxt = r_state;
        w_left_nxt  = r_left;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && w_burst_mode) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!w_burst_mode) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_cnt_zero) begin
                    if (i_burst_len == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_left_nxt  = i_burst_len;
                    end
                end
            end
            ST_RUN: begin
                if (!w_burst_mode) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_cnt_zero) begin
                    if (r_left == BURST_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_left_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_left_nxt = r_left - BURST_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output mux; burst blink is gated by the busy value being registered alongside it.
    always_comb begin
        w_blink_nxt = 1'b0;
        case (i_mode)
            MODE_OFF:   w_blink_nxt = 1'b0;
            MODE_ON:    w_blink_nxt = 1'b1;
            MODE_BLINK: w_blink_nxt = i_phase_hi;
            default:    w_blink_nxt = i_phase_hi && (w_state_nxt == ST_RUN);
        endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_left  <= '0;
            r_blink <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_left  <= w_left_nxt;
            r_blink <= w_blink_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= w_done_nxt;
        end
    end

    assign o_blink = r_blink;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: rtl/blink_gen.sv
// Multi-channel blink generator: shared period counter feeding N_CH channels.
module blink_gen
    import blink_gen_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PER_W   = 25,
    parameter int BURST_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PER_W-1:0]    period,
    input  logic [PER_W-1:0]    high_time,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     start,
    input  logic [BURST_W-1:0]  burst_len,
    output logic [N_CH-1:0]     blink,
    output logic                tick,
    output logic [N_CH-1:0]     busy,
    output logic [N_CH-1:0]     done
);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_period_q;
    logic [PER_W-1:0] r_high_q;
    logic             r_tick;

    logic [PER_W-1:0] w_period_eff;
    logic             w_wrap;
    logic             w_cnt_zero;
    logic             w_phase_hi;

    assign w_period_eff = (period < PER_W'(PER_MIN)) ? PER_W'(PER_MIN) : period;
    assign w_wrap       = (r_cnt >= (r_period_q - PER_W'(1)));
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_phase_hi   = (r_cnt < r_high_q);

    // Period counter; period/high settings are only taken at the wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_period_q <= w_period_eff;
            r_high_q   <= high_time;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= w_cnt_zero;
            if (w_wrap) begin
                r_cnt      <= '0;
                r_period_q <= w_period_eff;
                r_high_q   <= high_time;
            end else begin
                r_cnt <= r_cnt + PER_W'(1);
            end
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        blink_gen_ch #(
            .BURST_W (BURST_W)
        ) u_ch (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_mode      (mode[2*g +: 2]),
            .i_start     (start[g]),
            .i_burst_len (burst_len),
            .i_cnt_zero  (w_cnt_zero),
            .i_phase_hi  (w_phase_hi),
            .o_blink     (blink[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g])
        );
    end

endmodule
